// File: rtl/vram_window_arbiter.sv
// Object RAM arbiter: renderer has absolute priority; game requesters are served round-robin,
// one transaction at a time, only inside a per-frame window placed in vertical blanking.
module vram_window_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned AW          = 10,
    parameter int unsigned DW          = 16,
    parameter int unsigned VFRONT      = 480,
    parameter int unsigned MAXV        = 525,
    parameter int unsigned GUARD_LINES = 2,
    parameter int unsigned MAX_TXN     = 64
) (
    input  logic                  VGA_clk,
    input  logic                  reset_n,
    input  logic [9:0]            xCounter,
    input  logic [9:0]            yCounter,
    input  logic                  render_req,
    input  logic [AW-1:0]         render_addr,
    output logic                  render_valid,
    output logic [DW-1:0]         render_rdata,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    ack,
    output logic [DW-1:0]         ack_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    input  logic [DW-1:0]         mem_rdata,
    output logic                  window_open,
    output logic [7:0]            frame_cnt,
    output logic [6:0]            txn_cnt
);

    localparam int unsigned IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [9:0]  OpenLine  = 10'(VFRONT);
    localparam logic [9:0]  CloseLine = 10'(MAXV - GUARD_LINES);
    localparam logic [6:0]  TxnLimit  = 7'(MAX_TXN);

    typedef enum logic [1:0] {StScan, StOpen, StDone} win_state_e;
    typedef enum logic [1:0] {GIdle, GIssue, GWait} slot_state_e;

    win_state_e         win_q;
    slot_state_e        slot_q;
    logic [IW-1:0]      last_q;
    logic [IW-1:0]      owner_q;
    logic               render_p1_q;
    logic               ack_rd_q;

    logic               open_hit;
    logic               close_hit;
    logic               grant_ok;
    logic               pick_valid;
    logic [IW-1:0]      pick_idx;
    logic [IW-1:0]      cand;
    logic [NUM_REQ-1:0] pick_oh;
    logic               own_we;
    logic [AW-1:0]      own_addr;
    logic [DW-1:0]      own_wdata;

    assign open_hit  = (xCounter == 10'd0) && (yCounter == OpenLine);
    assign close_hit = (xCounter == 10'd0) && (yCounter == CloseLine);

    // Round-robin search starting just after the last served requester.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((32'(last_q) + k) % NUM_REQ);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign pick_oh  = NUM_REQ'(1) << pick_idx;
    // No new grant on the closing cycle itself, nor once the frame budget is spent.
    assign grant_ok = (win_q == StOpen) && !close_hit && pick_valid && (txn_cnt < TxnLimit);

    always_comb begin
        own_we    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IW'(i)) begin
                own_we    = req_we[i];
                own_addr  = req_addr[i*AW +: AW];
                own_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge VGA_clk) begin
        if (!reset_n) begin
            win_q        <= StScan;
            slot_q       <= GIdle;
            last_q       <= IW'(NUM_REQ - 1);
            owner_q      <= '0;
            render_p1_q  <= 1'b0;
            render_valid <= 1'b0;
            ack_rd_q     <= 1'b0;
            gnt          <= '0;
            ack          <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            frame_cnt    <= '0;
            txn_cnt      <= '0;
        end else begin
            ack          <= '0;
            ack_rd_q     <= 1'b0;
            render_p1_q  <= render_req;
            render_valid <= render_p1_q;

            unique case (win_q)
                StScan: begin
                    if (open_hit) begin
                        win_q     <= StOpen;
                        frame_cnt <= frame_cnt + 8'd1;
                        txn_cnt   <= '0;
                    end
                end
                StOpen: begin
                    if (close_hit)               win_q <= StScan;
                    else if (txn_cnt >= TxnLimit) win_q <= StDone;
                end
                StDone: begin
                    if (close_hit) win_q <= StScan;
                end
                default: win_q <= StScan;
            endcase

            unique case (slot_q)
                GIdle: begin
                    if (grant_ok) begin
                        gnt     <= pick_oh;
                        owner_q <= pick_idx;
                        txn_cnt <= txn_cnt + 7'd1;
                        slot_q  <= GIssue;
                    end
                end
                GIssue: begin
                    if (!render_req) slot_q <= GWait;
                end
                GWait: begin
                    ack      <= gnt;
                    ack_rd_q <= !own_we;
                    gnt      <= '0;
                    last_q   <= owner_q;
                    slot_q   <= GIdle;
                end
                default: slot_q <= GIdle;
            endcase

            // Address/data hold their last value while the port is idle.
            if (render_req) begin
                mem_en   <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= render_addr;
            end else if (slot_q == GIssue) begin
                mem_en    <= 1'b1;
                mem_we    <= own_we;
                mem_addr  <= own_addr;
                mem_wdata <= own_wdata;
            end else begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
            end
        end
    end

    assign window_open  = (win_q == StOpen);
    assign render_rdata = render_valid ? mem_rdata : '0;
    assign ack_rdata    = ack_rd_q ? mem_rdata : '0;

endmodule
